tx_delay_ch: RTL
================

TX_DELAY_CH -- requirements
Module: tx_delay_ch

Interface
REQ-001 Parameter ADDR_WD, default 7: delay-LUT address width, one entry per transmit line.
REQ-002 Parameter DLY_WD, default 12: transmit delay width, in clk cycles.
REQ-003 Parameter NCYC_WD, default 4: burst-cycle count width.
REQ-004 Parameter HALF_WD, default 4: half-period width, in clk cycles.
REQ-005 clk  in  1  sole clock; all logic is on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  fire request for line line_idx; sampled only in IDLE.
REQ-008 abort  in  1  synchronous abort of any firing in progress.
REQ-009 line_idx  in  ADDR_WD  LUT entry used at start.
REQ-010 lut_addr  in  ADDR_WD  delay-LUT write address.
REQ-011 lut_din  in  DLY_WD  delay-LUT write data.
REQ-012 lut_we  in  1  delay-LUT write enable.
REQ-013 num_cycles  in  NCYC_WD  burst length, in full pulse cycles.
REQ-014 half_period  in  HALF_WD  clocks per pulse half-cycle.
REQ-015 tx_p  out  1  positive pulser drive, registered.
REQ-016 tx_n  out  1  negative pulser drive, registered.
REQ-017 tx_en  out  1  transmit window; gates the receive channel's valid input.
REQ-018 busy  out  1  high whenever state is not IDLE.
REQ-019 done  out  1  one-cycle end-of-firing pulse.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, DELAY, FIRE_P, FIRE_N, DONE.
REQ-021 IDLE->FETCH SHALL occur when start=1; num_cycles and half_period SHALL be latched at that edge.
REQ-022 FETCH SHALL last exactly 1 cycle, performing a registered LUT read at line_idx into the delay counter.
REQ-023 DELAY SHALL last exactly D cycles, where D is the fetched value; D=0 SHALL go FETCH->FIRE_P directly.
REQ-024 With start sampled at edge 0, the first tx_p high cycle SHALL be cycle 2+D.
REQ-025 FIRE_P SHALL hold tx_p=1 for H cycles, then FIRE_N SHALL hold tx_n=1 for H cycles; this pair SHALL repeat num_cycles times.
REQ-026 H SHALL equal half_period, except half_period=0 SHALL be treated as H=1.
REQ-027 num_cycles=0 SHALL go from the end of DELAY to DONE with no pulses.
REQ-028 After the last FIRE_N, the FSM SHALL enter DONE for 1 cycle with done=1, then return to IDLE.
REQ-029 tx_en SHALL be 1 in FETCH, DELAY, FIRE_P and FIRE_N, and 0 in IDLE and DONE.
REQ-030 tx_p and tx_n SHALL never be 1 in the same cycle, and SHALL be 0 outside FIRE_P and FIRE_N respectively.
REQ-031 start while busy=1 SHALL be ignored; it SHALL not be queued.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with all outputs 0 and no done pulse.
REQ-033 abort has priority over start; start and abort together in IDLE SHALL leave the FSM in IDLE.
REQ-034 LUT writes SHALL be accepted in every state.
REQ-035 A write in FETCH to the same address being read SHALL return the old data (read-first).
REQ-036 A write after FETCH SHALL not affect the firing in progress.
REQ-037 The delay and half-period counters SHALL count down and SHALL not wrap; the maximum D = 2^DLY_WD-1 SHALL be honoured exactly.
REQ-038 Changes to num_cycles and half_period while busy SHALL have no effect on the firing in progress.

Reset
REQ-039 rst_n=0 SHALL asynchronously force state=IDLE, tx_p=0, tx_n=0, tx_en=0, busy=0, done=0, and clear all counters.
REQ-040 Reset mid-burst SHALL drop tx_p and tx_n immediately, without waiting for a clock edge.
REQ-041 LUT contents SHALL not be cleared by reset; they are undefined until written.
REQ-042 Reset release SHALL be synchronised externally; the first start SHALL be honoured on the 2nd edge after deassertion.

Structure
REQ-043 ADDR_WD, DLY_WD, NCYC_WD and HALF_WD defaults SHALL come from the shared param.h include used by the DBF channels.
REQ-044 State encodings SHALL be localparams inside the module.
REQ-045 The LUT SHALL be a sub-module tx_dly_lut: 2^ADDR_WD x DLY_WD, one write port, one registered read-first read port, inferrable as block RAM.
REQ-046 Everything else SHALL be in tx_delay_ch: FSM, counters and output registers.

Verification
REQ-047 LUT[3]=5, half_period=2, num_cycles=3, start at edge 0 with line_idx=3 -> tx_en 1..18; tx_p 7-8, 11-12, 15-16; tx_n 9-10, 13-14, 17-18; done at 19; busy=0 at 20.
REQ-048 LUT[0]=0, half_period=0, num_cycles=1 -> tx_p at 2; tx_n at 3; done at 4.
REQ-049 num_cycles=0, D=4 -> no tx_p or tx_n; tx_en 1..5; done at 6.
REQ-050 Abort at cycle 9 of the REQ-047 case -> all outputs 0 from cycle 10; no done; a new start at 12 is accepted.
REQ-051 start pulsed at cycles 5 and 10 during a firing -> ignored, and the timing is identical to REQ-047.
REQ-052 lut_we to address 3 with value 9 at edge 1 of the REQ-047 case -> the old delay of 5 is used; the next firing uses 9, so its first tx_p is at start+11.
REQ-053 rst_n=0 asserted mid-FIRE_P -> tx_p=0 asynchronously, before the next edge.

Source files
------------

// File: rtl/tx_delay_ch_pkg.sv
// Shared sizing defaults for the transmit delay channel and its delay LUT.
package tx_delay_ch_pkg;

  // Default widths shared with the DBF channels
  localparam int unsigned TxAddrWd = 7;   // one LUT entry per transmit line
  localparam int unsigned TxDlyWd  = 12;  // transmit delay, clk cycles
  localparam int unsigned TxNcycWd = 4;   // burst length, full pulse cycles
  localparam int unsigned TxHalfWd = 4;   // pulse half-period, clk cycles

  // Number of LUT entries for a given address width
  function automatic int unsigned lut_depth(input int unsigned addr_wd);
    return 32'd1 << addr_wd;
  endfunction

endpackage

// File: rtl/tx_dly_lut.sv
// Per-line transmit delay table: one write port, one registered read-first read port.
// No reset on the array or read register so the table maps onto block RAM.
module tx_dly_lut
  import tx_delay_ch_pkg::*;
#(
  parameter int unsigned AddrWd = TxAddrWd,
  parameter int unsigned DlyWd  = TxDlyWd
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AddrWd-1:0] waddr_i,
  input  logic [DlyWd-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [AddrWd-1:0] raddr_i,
  output logic [DlyWd-1:0]  rdata_o
);

  localparam int unsigned Depth = lut_depth(AddrWd);

  logic [DlyWd-1:0] mem_q [Depth];
  logic [DlyWd-1:0] rdata_q;

  // Write and read on the same edge; the read sees the pre-write contents
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tx_delay_ch.sv
// Transmit delay channel: on start, fetch the line's delay from the LUT, wait it out,
// then drive a bipolar burst of num_cycles pulse pairs with a programmable half-period.
module tx_delay_ch
  import tx_delay_ch_pkg::*;
#(
  parameter int unsigned ADDR_WD = TxAddrWd,
  parameter int unsigned DLY_WD  = TxDlyWd,
  parameter int unsigned NCYC_WD = TxNcycWd,
  parameter int unsigned HALF_WD = TxHalfWd
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_WD-1:0] line_idx,
  input  logic [ADDR_WD-1:0] lut_addr,
  input  logic [DLY_WD-1:0]  lut_din,
  input  logic               lut_we,
  input  logic [NCYC_WD-1:0] num_cycles,
  input  logic [HALF_WD-1:0] half_period,
  output logic               tx_p,
  output logic               tx_n,
  output logic               tx_en,
  output logic               busy,
  output logic               done
);

  // State encodings
  localparam logic [2:0] StIdleEnc  = 3'd0;
  localparam logic [2:0] StFetchEnc = 3'd1;
  localparam logic [2:0] StDelayEnc = 3'd2;
  localparam logic [2:0] StFirePEnc = 3'd3;
  localparam logic [2:0] StFireNEnc = 3'd4;
  localparam logic [2:0] StDoneEnc  = 3'd5;

  typedef enum logic [2:0] {
    StIdle  = StIdleEnc,
    StFetch = StFetchEnc,
    StDelay = StDelayEnc,
    StFireP = StFirePEnc,
    StFireN = StFireNEnc,
    StDone  = StDoneEnc
  } state_e;

  localparam logic [DLY_WD-1:0]  DlyOne  = DLY_WD'(1);
  localparam logic [NCYC_WD-1:0] NcycOne = NCYC_WD'(1);
  localparam logic [HALF_WD-1:0] HalfOne = HALF_WD'(1);

  state_e               state_q, state_d;
  logic [DLY_WD-1:0]    dly_cnt_q, dly_cnt_d;
  logic [HALF_WD-1:0]   half_cnt_q, half_cnt_d;
  logic [HALF_WD-1:0]   half_lat_q, half_lat_d;
  logic [NCYC_WD-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic                 tx_p_q, tx_p_d;
  logic                 tx_n_q, tx_n_d;
  logic                 tx_en_q, tx_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 lut_re;
  logic [DLY_WD-1:0]    lut_rdata;
  state_e               burst_state;

  // Delay LUT; read is launched on the start edge so data is ready during FETCH
  tx_dly_lut #(
    .AddrWd (ADDR_WD),
    .DlyWd  (DLY_WD)
  ) u_lut (
    .clk_i   (clk),
    .we_i    (lut_we),
    .waddr_i (lut_addr),
    .wdata_i (lut_din),
    .re_i    (lut_re),
    .raddr_i (line_idx),
    .rdata_o (lut_rdata)
  );

  // Where the delay phase hands over to: the burst, or straight to DONE for an empty burst
  assign burst_state = (cyc_cnt_q != '0) ? StFireP : StDone;

  // Next-state and counter update; counters count down and stop at one, never wrapping
  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    half_cnt_d = half_cnt_q;
    half_lat_d = half_lat_q;
    cyc_cnt_d  = cyc_cnt_q;
    lut_re     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d    = StFetch;
          lut_re     = 1'b1;
          // Burst shape is frozen here; later input changes do not reach this firing
          cyc_cnt_d  = num_cycles;
          half_lat_d = (half_period == '0) ? HalfOne : half_period;
        end
      end

      StFetch: begin
        dly_cnt_d  = lut_rdata;
        half_cnt_d = half_lat_q;
        if (lut_rdata != '0) begin
          state_d = StDelay;
        end else begin
          state_d = burst_state;
        end
      end

      StDelay: begin
        if (dly_cnt_q <= DlyOne) begin
          dly_cnt_d  = '0;
          half_cnt_d = half_lat_q;
          state_d    = burst_state;
        end else begin
          dly_cnt_d = dly_cnt_q - DlyOne;
        end
      end

      StFireP: begin
        if (half_cnt_q <= HalfOne) begin
          half_cnt_d = half_lat_q;
          state_d    = StFireN;
        end else begin
          half_cnt_d = half_cnt_q - HalfOne;
        end
      end

      StFireN: begin
        if (half_cnt_q <= HalfOne) begin
          if (cyc_cnt_q <= NcycOne) begin
            cyc_cnt_d  = '0;
            half_cnt_d = '0;
            state_d    = StDone;
          end else begin
            cyc_cnt_d  = cyc_cnt_q - NcycOne;
            half_cnt_d = half_lat_q;
            state_d    = StFireP;
          end
        end else begin
          half_cnt_d = half_cnt_q - HalfOne;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over everything and leaves no trace of the firing
    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      dly_cnt_d  = '0;
      half_cnt_d = '0;
      half_lat_d = '0;
      cyc_cnt_d  = '0;
    end
  end

  // Outputs decoded from the next state so the registered copies line up with the state
  always_comb begin
    tx_p_d  = (state_d == StFireP);
    tx_n_d  = (state_d == StFireN);
    tx_en_d = (state_d == StFetch) || (state_d == StDelay) ||
              (state_d == StFireP) || (state_d == StFireN);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  // State, counters and output registers; reset drops the pulser drive immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dly_cnt_q  <= '0;
      half_cnt_q <= '0;
      half_lat_q <= '0;
      cyc_cnt_q  <= '0;
      tx_p_q     <= 1'b0;
      tx_n_q     <= 1'b0;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      half_cnt_q <= half_cnt_d;
      half_lat_q <= half_lat_d;
      cyc_cnt_q  <= cyc_cnt_d;
      tx_p_q     <= tx_p_d;
      tx_n_q     <= tx_n_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_p  = tx_p_q;
  assign tx_n  = tx_n_q;
  assign tx_en = tx_en_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
